seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Time-multiplexed 4-digit seven-segment display driver. It sits directly downstream of the binary-to-BCD converter and takes that stage's 16-bit packed BCD output (four digits, digit 3 in bits [15:12]). It latches a value on a load strobe, scans the four common-anode digits round-robin at a programmable rate, blanks leading zeros and drives active-low anode, segment and decimal-point pins with registered outputs.

## Interface
- SCAN_DIV, default 100000: clock cycles each digit stays lit. Legal range is ≥1.
- BLANK_LZ, default 1: 1 enables leading-zero blanking; 0 always shows all four digits.

- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bcd_in  input  16  packed BCD from the converter; digit k is bcd_in[4k+3:4k].
- load  input  1  1-cycle strobe; captures bcd_in and dp_in.
- dp_in  input  4  decimal-point request per digit (bit k = digit k).
- blank  input  1  level; 1 turns the whole display off.
- an  output  4  active-low anode select; an[k]=0 lights digit k.
- seg  output  7  active-low segments, {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.

## Operation
- Display register (disp[15:0], dpr[3:0]):
  - Loaded from bcd_in/dp_in on any edge where load=1 and rst=0.
  - Otherwise it holds its value.
  - Reset value is 0.
- Prescaler (pcnt):
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - Its width is clog2(SCAN_DIV), minimum 1.
  - When pcnt=SCAN_DIV-1, the digit index idx[1:0] increments 0→1→2→3→0.
  - With SCAN_DIV=1, idx increments every cycle.
- Leading-zero blanking, evaluated from disp/dpr:
  - Digit k (k=3..1) is suppressed when BLANK_LZ=1, every digit j≥k has value 0, and dpr[j]=0 for all j≥k.
  - Digit 0 is never suppressed.
  - Setting a dp bit stops suppression at that digit and all digits below it, so a value with dpr=4'b0010 shows "0.5" rather than ".5".
- Segment decode, seg values in hex:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - Nibbles 10–15 display a dash: seg=3F.
- Output register, computed every cycle from the current idx/disp/dpr/blank:
  - If blank=1 or digit idx is suppressed: an=4'hF, seg=7'h7F, dp=1.
  - Otherwise: an = ~(1<<idx), seg = decode(digit idx), dp = ~dpr[idx].
- Scanning continues while blank=1. Removing blank resumes at whatever idx the scan has reached; it does not restart at digit 0.

## Timing
- Reset (rst=1 at an edge):
  - pcnt=0, idx=0, disp=0, dpr=0.
  - an=4'hF, seg=7'h7F, dp=1.
  - Reset wins over a simultaneous load.
- First edge after reset release: outputs show digit 0 of disp=0, i.e. an=4'hE, seg=7'h40, dp=1.
- Load latency:
  - disp updates at the load edge.
  - Pins reflect the new value at the following edge, even if that falls in the middle of a digit's dwell.
- Scan timing:
  - Each digit is driven for exactly SCAN_DIV cycles.
  - Pins lag idx by 1 cycle.
  - One full frame is 4·SCAN_DIV cycles.
- blank latency: 1 cycle to take effect and 1 cycle to release.
- Back-to-back load pulses: the last one wins. No handshake or backpressure is needed, because load is always accepted.
- Reset asserted mid-frame: everything returns to the reset state at that edge and scanning restarts from digit 0.

## Test plan
All scenarios use SCAN_DIV=4 unless stated otherwise.
- Reset/idle:
  - Hold rst for 3 cycles → an=F, seg=7F, dp=1.
  - Release → an=E, seg=40 at the next edge.
  - an sequence thereafter is E,D,B,7, each held 4 cycles.
- Full value:
  - load bcd_in=16'h1234, dp_in=0 → digit 0 shows seg=19 (4), then 30 (3), 24 (2), 79 (1).
  - Each digit appears on the correct an one cycle after idx changes.
- Leading zeros:
  - bcd_in=16'h0007 with BLANK_LZ=1 → an=F during slots 3..1; digit 0 shows seg=78.
  - Same value with BLANK_LZ=0 → digits 3..1 show seg=40.
- Decimal point:
  - bcd_in=16'h0005, dp_in=4'b0010 → digit 1 shows seg=40 with dp=0.
  - Digit 0 shows seg=12 with dp=1.
  - Digits 3 and 2 are blanked.
- Invalid nibble and blank:
  - bcd_in=16'hA0F9 → digits 3 and 1 show seg=3F, digit 2 shows 40, digit 0 shows 10.
  - Assert blank for 6 cycles → an=F one cycle later; scan position advances uninterrupted.
- Mid-operation events:
  - load plus rst in the same cycle → disp stays 0.
  - load mid-digit → pins change on the next edge.
  - With SCAN_DIV=1 → an cycles E,D,B,7 on consecutive cycles.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// Latches packed BCD on load, scans digits round-robin, blanks leading zeros, registered active-low pins.
module seg_scan_display #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_BAD = 7'h3F;

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [3:0]    dpr;

    logic          lz3;
    logic          lz2;
    logic          lz1;
    logic [3:0]    supp;
    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg;

    // Active-low {g,f,e,d,c,b,a}; non-BCD nibbles render as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        // NOTE: the default arm covers every unlisted value, so no latch can be inferred.
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = SEG_BAD;
        endcase
    endfunction

    // Prescaler and digit index; idx advances on the last count of each dwell.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            pcnt <= '0;
            idx  <= 2'd0;
        end else if (pcnt == PCNT_MAX) begin
            pcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp <= 16'h0000;
            dpr  <= 4'h0;
        end else if (load) begin
            disp <= bcd_in;
            dpr  <= dp_in;
        end
    end

    // A digit is suppressed only while it and every digit above it are zero with no dp lit.
    assign lz3  = BLANK_LZ && (disp[15:12] == 4'd0) && !dpr[3];
    assign lz2  = lz3 && (disp[11:8] == 4'd0) && !dpr[2];
    assign lz1  = lz2 && (disp[7:4] == 4'd0) && !dpr[1];
    assign supp = {lz3, lz2, lz1, 1'b0};

    assign cur_digit = disp[{idx, 2'b00} +: 4];
    assign cur_seg   = seg_decode(cur_digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (blank || supp[idx]) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= cur_seg;
            dp  <= ~dpr[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: three instances cover SCAN_DIV=4 with and without
// leading-zero blanking, and SCAN_DIV=1.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank = 1'b0;

    logic [3:0] an_m, an_n, an_f;
    logic [6:0] seg_m, seg_n, seg_f;
    logic       dp_m, dp_n, dp_f;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_main (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .dp_in(dp_in), .blank(blank),
        .an(an_m), .seg(seg_m), .dp(dp_m)
    );

    seg_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_nolz (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .dp_in(dp_in), .blank(blank),
        .an(an_n), .seg(seg_n), .dp(dp_n)
    );

    seg_scan_display #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) u_fast (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .dp_in(dp_in), .blank(blank),
        .an(an_f), .seg(seg_f), .dp(dp_f)
    );

    // One clock; outputs are sampled and inputs driven on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Reset, then load a value on the first edge after release; returns with cyc=1.
    task automatic start(input logic [15:0] v, input logic [3:0] d);
        rst   = 1'b1;
        load  = 1'b0;
        blank = 1'b0;
        step();
        step();
        rst    = 1'b0;
        bcd_in = v;
        dp_in  = d;
        load   = 1'b1;
        cyc    = 0;
        step();
        load = 1'b0;
    endtask

    function automatic int slot4(input int n);
        return ((n - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic test_reset();
        int d;
        rst = 1'b1;
        load = 1'b0;
        step();
        step();
        step();
        n_cmp++;
        if ({an_m, seg_m, dp_m} !== {4'hF, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_main: got an=%h seg=%h dp=%b want an=F seg=7F dp=1", an_m, seg_m, dp_m);
        end
        n_cmp++;
        if ({an_f, seg_f, dp_f} !== {4'hF, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_fast: got an=%h seg=%h dp=%b want an=F seg=7F dp=1", an_f, seg_f, dp_f);
        end
        rst = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 16; n++) begin
            step();
            d = slot4(n);
            n_cmp++;
            if ({an_m, seg_m, dp_m} !== {(d == 0) ? 4'hE : 4'hF, (d == 0) ? 7'h40 : 7'h7F, 1'b1}) begin
                n_fail++;
                $display("FAIL idle_main cyc%0d: got an=%h seg=%h dp=%b want slot %0d", n, an_m, seg_m, dp_m, d);
            end
            n_cmp++;
            if ({an_n, seg_n, dp_n} !== {an_of(d), 7'h40, 1'b1}) begin
                n_fail++;
                $display("FAIL idle_nolz cyc%0d: got an=%h seg=%h dp=%b want an=%h seg=40 dp=1",
                         n, an_n, seg_n, dp_n, an_of(d));
            end
        end
    endtask

    task automatic test_full_value();
        logic [6:0] es [4];
        int d;
        es = '{7'h19, 7'h30, 7'h24, 7'h79};
        start(16'h1234, 4'h0);
        for (int n = 2; n <= 17; n++) begin
            step();
            d = slot4(n);
            n_cmp++;
            if ({an_m, seg_m, dp_m} !== {an_of(d), es[d], 1'b1}) begin
                n_fail++;
                $display("FAIL full_value cyc%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=1",
                         n, an_m, seg_m, dp_m, an_of(d), es[d]);
            end
        end
    endtask

    task automatic test_leading_zeros();
        logic [3:0] ea [4];
        logic [6:0] es [4];
        logic [6:0] esn [4];
        int d;
        ea  = '{4'hE, 4'hF, 4'hF, 4'hF};
        es  = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
        esn = '{7'h78, 7'h40, 7'h40, 7'h40};
        start(16'h0007, 4'h0);
        for (int n = 2; n <= 17; n++) begin
            step();
            d = slot4(n);
            n_cmp++;
            if ({an_m, seg_m, dp_m} !== {ea[d], es[d], 1'b1}) begin
                n_fail++;
                $display("FAIL lz_on cyc%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=1",
                         n, an_m, seg_m, dp_m, ea[d], es[d]);
            end
            n_cmp++;
            if ({an_n, seg_n, dp_n} !== {an_of(d), esn[d], 1'b1}) begin
                n_fail++;
                $display("FAIL lz_off cyc%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=1",
                         n, an_n, seg_n, dp_n, an_of(d), esn[d]);
            end
        end
    endtask

    task automatic test_decimal_point();
        logic [3:0] ea [4];
        logic [6:0] es [4];
        logic       ed [4];
        int d;
        ea = '{4'hE, 4'hD, 4'hF, 4'hF};
        es = '{7'h12, 7'h40, 7'h7F, 7'h7F};
        ed = '{1'b1, 1'b0, 1'b1, 1'b1};
        start(16'h0005, 4'b0010);
        for (int n = 2; n <= 17; n++) begin
            step();
            d = slot4(n);
            n_cmp++;
            if ({an_m, seg_m, dp_m} !== {ea[d], es[d], ed[d]}) begin
                n_fail++;
                $display("FAIL dp cyc%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         n, an_m, seg_m, dp_m, ea[d], es[d], ed[d]);
            end
        end
    endtask

    task automatic test_invalid_and_blank();
        logic [6:0] es [4];
        int d;
        logic bl;
        es = '{7'h10, 7'h3F, 7'h40, 7'h3F};
        start(16'hA0F9, 4'h0);
        for (int n = 2; n <= 28; n++) begin
            step();
            d  = slot4(n);
            bl = (n >= 18) && (n <= 23);
            n_cmp++;
            if ({an_m, seg_m, dp_m} !== {bl ? 4'hF : an_of(d), bl ? 7'h7F : es[d], 1'b1}) begin
                n_fail++;
                $display("FAIL inv_blank cyc%0d: got an=%h seg=%h dp=%b want blank=%b slot %0d",
                         n, an_m, seg_m, dp_m, bl, d);
            end
            if (n == 17) blank = 1'b1;
            if (n == 23) blank = 1'b0;
        end
    endtask

    task automatic test_mid_events();
        int d;
        // load coincident with reset must be ignored
        rst    = 1'b1;
        bcd_in = 16'h1234;
        dp_in  = 4'hF;
        load   = 1'b1;
        step();
        load = 1'b0;
        step();
        rst = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            d = slot4(n);
            n_cmp++;
            if ({an_n, seg_n, dp_n} !== {an_of(d), 7'h40, 1'b1}) begin
                n_fail++;
                $display("FAIL load_rst cyc%0d: got an=%h seg=%h dp=%b want an=%h seg=40 dp=1",
                         n, an_n, seg_n, dp_n, an_of(d));
            end
        end

        // load in the middle of digit 1's dwell, then back-to-back loads
        start(16'h1234, 4'h0);
        for (int n = 2; n <= 6; n++) step();
        bcd_in = 16'h5678;
        load   = 1'b1;
        step();
        load = 1'b0;
        n_cmp++;
        if ({an_m, seg_m} !== {4'hD, 7'h30}) begin
            n_fail++;
            $display("FAIL mid_load_old cyc%0d: got an=%h seg=%h want an=D seg=30", cyc, an_m, seg_m);
        end
        step();
        n_cmp++;
        if ({an_m, seg_m} !== {4'hD, 7'h78}) begin
            n_fail++;
            $display("FAIL mid_load_new cyc%0d: got an=%h seg=%h want an=D seg=78", cyc, an_m, seg_m);
        end
        step();
        n_cmp++;
        if ({an_m, seg_m} !== {4'hB, 7'h02}) begin
            n_fail++;
            $display("FAIL mid_load_d2 cyc%0d: got an=%h seg=%h want an=B seg=02", cyc, an_m, seg_m);
        end
        bcd_in = 16'h1111;
        load   = 1'b1;
        step();
        bcd_in = 16'h2222;
        step();
        load = 1'b0;
        n_cmp++;
        if ({an_m, seg_m} !== {4'hB, 7'h79}) begin
            n_fail++;
            $display("FAIL b2b_first cyc%0d: got an=%h seg=%h want an=B seg=79", cyc, an_m, seg_m);
        end
        step();
        n_cmp++;
        if ({an_m, seg_m} !== {4'hB, 7'h24}) begin
            n_fail++;
            $display("FAIL b2b_last cyc%0d: got an=%h seg=%h want an=B seg=24", cyc, an_m, seg_m);
        end

        // reset mid-frame returns to the reset state and restarts at digit 0
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({an_m, seg_m, dp_m} !== {4'hF, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_hold: got an=%h seg=%h dp=%b want an=F seg=7F dp=1", an_m, seg_m, dp_m);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({an_n, seg_n, dp_n} !== {4'hE, 7'h40, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_restart: got an=%h seg=%h dp=%b want an=E seg=40 dp=1", an_n, seg_n, dp_n);
        end
    endtask

    task automatic test_fast_scan();
        logic [6:0] es [4];
        int d;
        es = '{7'h19, 7'h30, 7'h24, 7'h79};
        start(16'h1234, 4'h0);
        for (int n = 2; n <= 9; n++) begin
            step();
            d = (n - 1) % 4;
            n_cmp++;
            if ({an_f, seg_f, dp_f} !== {an_of(d), es[d], 1'b1}) begin
                n_fail++;
                $display("FAIL fast_scan cyc%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=1",
                         n, an_f, seg_f, dp_f, an_of(d), es[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_value();
        test_leading_zeros();
        test_decimal_point();
        test_invalid_and_blank();
        test_mid_events();
        test_fast_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
